tb_vp_status: RTL and testbench
===============================

// Module: tb_vp_status
//
// PURPOSE
// - Virtual-peripheral slave on the core data bus inside the core testbench wrapper; upstream of the top-level pass/fail/exit checker.
// - Decodes stores to magic addresses into test status, exit code, stdout characters and a countdown timer interrupt.
// - Exposes a free-running cycle counter for reads.
// - Sticky status outputs feed the checker, which ends simulation on the first clock edge at which any of them is high.
//
// PARAMETERS
// - FIFO_DEPTH  8   stdout char FIFO entries; power of 2, >=2
// - PASS_MAGIC  32'd123456789  TEST_STATUS value meaning pass
// - FAIL_MAGIC  32'd1          TEST_STATUS value meaning fail
//
// PORTS
// - clk_i            in   1   clock, all logic on rising edge
// - rst_i            in   1   reset, synchronous, active-high
// - req_i            in   1   bus request
// - we_i             in   1   1=write, 0=read
// - addr_i           in   32  byte address, word aligned
// - be_i             in   4   byte enables; ignored except PRINT (uses byte 0)
// - wdata_i          in   32  write data
// - gnt_o            out  1   request accepted this cycle
// - rvalid_o         out  1   response valid, exactly 1 cycle after grant
// - rdata_o          out  32  read data, valid with rvalid_o
// - char_valid_o     out  1   stdout FIFO head valid
// - char_o           out  8   stdout FIFO head byte
// - char_ready_i     in   1   consumer pops head when valid&ready
// - irq_timer_o      out  1   one-cycle timer expiry pulse
// - tests_passed_o   out  1   sticky pass
// - tests_failed_o   out  1   sticky fail
// - exit_valid_o     out  1   sticky exit request
// - exit_value_o     out  32  exit code, latched with exit_valid_o
//
// BEHAVIOUR
// - Reset (rst_i high at an edge): all outputs 0, FIFO empty, timer idle, cycle counter 0. Reset mid-transaction drops a pending rvalid and flushes the FIFO.
// - Handshake: transfer when req_i&gnt_o. gnt_o = req_i & ~(we_i & addr==PRINT & fifo_full). Combinational from req/we/addr/registered full only; never from char_ready_i.
// - Response: rvalid_o=1 in the cycle after every grant, reads and writes alike. Back-to-back grants allowed, giving one rvalid per cycle.
// - Address map (in tb_vp_pkg):
//   - PRINT 0x1000_0000 W: push wdata_i[7:0]
//   - TIMER 0x1500_0000 W: load countdown; R: current count
//   - CYCLE 0x1500_0004 R: cycle counter
//   - TEST_STATUS 0x2000_0000 W
//   - EXIT 0x2000_0004 W
// - Unmapped reads return 0. Unmapped writes are ignored but still granted and answered. Reads of write-only registers return 0.
// - TEST_STATUS: PASS_MAGIC sets tests_passed_o; FAIL_MAGIC sets tests_failed_o; other values ignored. Both flags stay set until reset, and both may end up high together.
// - EXIT: the first write sets exit_valid_o and exit_value_o=wdata_i on the next edge. Later writes are ignored; the value is frozen.
// - Cycle counter: 32-bit, +1 every cycle out of reset, wraps 0xFFFF_FFFF->0.
// - Timer: write N loads count=N, and N=0 disables. Each cycle with count>0: count-1. The transition 1->0 raises irq_timer_o for exactly one cycle. If a TIMER write coincides with the 1->0 cycle, the write wins and no irq is raised.
// - FIFO: pushes come from granted PRINT writes; pops on char_valid_o&char_ready_i. Simultaneous push+pop is legal when not full, and occupancy is unchanged. When full the store is stalled (gnt_o=0) until a pop frees a slot on the following cycle. Wrap-around uses pointers one bit wider than log2(FIFO_DEPTH).
//
// STRUCTURE
// - tb_vp_pkg: address constants, PASS/FAIL magics, reg-select enum {SEL_NONE,SEL_PRINT,SEL_TIMER,SEL_CYCLE,SEL_STATUS,SEL_EXIT}.
// - Sub-module tb_vp_fifo (sync FIFO, WIDTH/DEPTH params, push/pop/full/empty). The rest is flat: decode, response register, status, timer and counter.
//
// TESTING
// - Reset for 3 cycles, then idle -> all outputs 0; CYCLE read after 10 cycles returns 10 +/-1 (exact value pinned by the bench).
// - Store 0x41,0x42,0x43 to PRINT with char_ready_i=0 -> FIFO holds 3 entries; char_o=0x41 first; raising ready drains A,B,C in order.
// - Fill FIFO (8 stores, ready=0); 9th store -> gnt_o=0; one pop -> grant the next cycle; order preserved; simultaneous push+pop at 7 entries keeps count 7.
// - Write TIMER=5 -> irq_timer_o pulses once exactly 5 cycles later. Rewrite TIMER=3 on the expiry cycle -> no pulse then, pulse 3 cycles later.
// - Write TEST_STATUS=123456789 -> tests_passed_o=1 next cycle and held. Write EXIT=7 then EXIT=0 -> exit_valid_o=1, exit_value_o=7.
// - Read 0x3000_0000 -> rvalid_o next cycle with rdata_o=0. Assert rst_i while a read is pending -> no rvalid_o, FIFO empty.

Source files
------------

// File: rtl/tb_vp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tb_vp_pkg
// Description : Shared definitions for the testbench virtual peripheral.
//               Holds the magic store addresses, the default pass/fail status
//               codes, the register-select enum and the address decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package tb_vp_pkg;

  // Magic addresses. Only exact word addresses match.
  localparam logic [31:0] ADDR_PRINT  = 32'h1000_0000;
  localparam logic [31:0] ADDR_TIMER  = 32'h1500_0000;
  localparam logic [31:0] ADDR_CYCLE  = 32'h1500_0004;
  localparam logic [31:0] ADDR_STATUS = 32'h2000_0000;
  localparam logic [31:0] ADDR_EXIT   = 32'h2000_0004;

  // Default TEST_STATUS codes; the top module can override them.
  localparam logic [31:0] DEFAULT_PASS_MAGIC = 32'd123456789;
  localparam logic [31:0] DEFAULT_FAIL_MAGIC = 32'd1;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_PRINT  = 3'd1,
    SEL_TIMER  = 3'd2,
    SEL_CYCLE  = 3'd3,
    SEL_STATUS = 3'd4,
    SEL_EXIT   = 3'd5
  } sel_e;

  // Maps a bus address onto the register it selects.
  function automatic sel_e decode_addr(input logic [31:0] addr);
    sel_e sel;
    sel = SEL_NONE;
    case (addr)
      ADDR_PRINT:  sel = SEL_PRINT;
      ADDR_TIMER:  sel = SEL_TIMER;
      ADDR_CYCLE:  sel = SEL_CYCLE;
      ADDR_STATUS: sel = SEL_STATUS;
      ADDR_EXIT:   sel = SEL_EXIT;
      default:     sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tb_vp_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_vp_fifo
// Description : Single-clock FIFO used to buffer stdout characters.
//               Pointers carry one extra wrap bit so that full and empty can
//               be told apart when the index bits are equal.
// Ports       : clk, rst          clock, synchronous active-high reset
//               push, wdata       write strobe and data (ignored when full)
//               pop               read strobe (ignored when empty)
//               rdata             head entry (meaningful when !empty)
//               full, empty       occupancy flags, derived from registers
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  // Guard the strobes so an over/underflow attempt cannot corrupt pointers.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: nothing is visible until a push has written it.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule
`default_nettype wire

// File: rtl/tb_vp_status.sv
`default_nettype none
// ============================================================================
// Module      : tb_vp_status
// Description : Virtual peripheral on the core data bus. Stores to magic
//               addresses become test status, exit code, stdout characters
//               and a countdown timer interrupt; a free-running cycle counter
//               and the timer count can be read back.
// Ports       : clk_i, rst_i                 clock, sync active-high reset
//               req_i, we_i, addr_i, be_i,   bus request side
//               wdata_i
//               gnt_o, rvalid_o, rdata_o     bus grant and response
//               char_valid_o, char_o,        stdout character stream
//               char_ready_i
//               irq_timer_o                  one-cycle timer expiry pulse
//               tests_passed_o,              sticky status to the checker
//               tests_failed_o,
//               exit_valid_o, exit_value_o
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vp_status
  import tb_vp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] PASS_MAGIC = DEFAULT_PASS_MAGIC,
  parameter logic [31:0] FAIL_MAGIC = DEFAULT_FAIL_MAGIC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        char_valid_o,
  output logic [7:0]  char_o,
  input  logic        char_ready_i,
  output logic        irq_timer_o,
  output logic        tests_passed_o,
  output logic        tests_failed_o,
  output logic        exit_valid_o,
  output logic [31:0] exit_value_o
);

  // --------------------------------------------------------------------------
  // Decode and handshake
  // --------------------------------------------------------------------------
  sel_e        sel;
  logic        fifo_full;
  logic        fifo_empty;
  logic        wr_xfer;
  logic        rd_xfer;
  logic        print_push;
  logic        timer_wr;
  logic        status_wr;
  logic        exit_wr;
  logic [31:0] read_data;
  logic        unused_be;

  assign sel = decode_addr(addr_i);

  // Only a PRINT store into a full FIFO is held off. fifo_full comes straight
  // from the FIFO pointer registers, so no path exists from char_ready_i.
  assign gnt_o = req_i & ~(we_i & (sel == SEL_PRINT) & fifo_full);

  assign wr_xfer    = gnt_o & we_i;
  assign rd_xfer    = gnt_o & ~we_i;
  assign print_push = wr_xfer & (sel == SEL_PRINT) & be_i[0];
  assign timer_wr   = wr_xfer & (sel == SEL_TIMER);
  assign status_wr  = wr_xfer & (sel == SEL_STATUS);
  assign exit_wr    = wr_xfer & (sel == SEL_EXIT);

  // Upper byte enables have no meaning for any register here.
  assign unused_be = ^be_i[3:1];

  // --------------------------------------------------------------------------
  // Cycle counter
  // --------------------------------------------------------------------------
  logic [31:0] cycle_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) cycle_count <= '0;
    else       cycle_count <= cycle_count + 32'd1;
  end

  // --------------------------------------------------------------------------
  // Countdown timer
  // --------------------------------------------------------------------------
  logic [31:0] timer_count;
  logic        timer_irq;

  // A write takes priority over the decrement, so a reload landing on the
  // 1->0 cycle suppresses that expiry pulse. Loading 0 leaves it idle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timer_count <= '0;
      timer_irq   <= 1'b0;
    end else if (timer_wr) begin
      timer_count <= wdata_i;
      timer_irq   <= 1'b0;
    end else if (timer_count != 32'd0) begin
      timer_count <= timer_count - 32'd1;
      timer_irq   <= (timer_count == 32'd1);
    end else begin
      timer_irq   <= 1'b0;
    end
  end

  assign irq_timer_o = timer_irq;

  // --------------------------------------------------------------------------
  // Sticky status and exit code
  // --------------------------------------------------------------------------
  logic        passed;
  logic        failed;
  logic        exit_valid;
  logic [31:0] exit_value;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      passed <= 1'b0;
      failed <= 1'b0;
    end else if (status_wr) begin
      if (wdata_i == PASS_MAGIC) passed <= 1'b1;
      if (wdata_i == FAIL_MAGIC) failed <= 1'b1;
    end
  end

  // The first EXIT store wins; the code is frozen afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      exit_valid <= 1'b0;
      exit_value <= '0;
    end else if (exit_wr && !exit_valid) begin
      exit_valid <= 1'b1;
      exit_value <= wdata_i;
    end
  end

  assign tests_passed_o = passed;
  assign tests_failed_o = failed;
  assign exit_valid_o   = exit_valid;
  assign exit_value_o   = exit_value;

  // --------------------------------------------------------------------------
  // Read mux and response register
  // --------------------------------------------------------------------------
  // Write-only and unmapped registers read back as zero.
  always_comb begin
    read_data = '0;
    case (sel)
      SEL_TIMER: read_data = timer_count;
      SEL_CYCLE: read_data = cycle_count;
      default:   read_data = '0;
    endcase
  end

  logic        rsp_valid;
  logic [31:0] rsp_data;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= gnt_o;
      rsp_data  <= rd_xfer ? read_data : 32'd0;
    end
  end

  assign rvalid_o = rsp_valid;
  assign rdata_o  = rsp_data;

  // --------------------------------------------------------------------------
  // Stdout character FIFO
  // --------------------------------------------------------------------------
  tb_vp_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_char_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (print_push),
    .wdata (wdata_i[7:0]),
    .pop   (char_ready_i),
    .rdata (char_o),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign char_valid_o = ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_tb_vp_status.sv
`default_nettype none
// ============================================================================
// Module      : tb_tb_vp_status
// Description : Self-checking bench for tb_vp_status. A behavioural model
//               (character queue, integer timer, plain counters) tracks the
//               expected peripheral state; directed scenarios and a random
//               phase compare the DUT outputs against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tb_vp_status;
  import tb_vp_pkg::*;

  localparam int unsigned DEPTH = 8;
  localparam logic [31:0] PASS_CODE = 32'd123456789;
  localparam logic [31:0] FAIL_CODE = 32'd1;
  localparam logic [31:0] ADDR_UNMAPPED = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  be = 4'hF;
  logic [31:0] wdata = '0;
  logic        char_ready = 1'b0;

  logic        gnt_o, rvalid_o, char_valid_o, irq_timer_o;
  logic        tests_passed_o, tests_failed_o, exit_valid_o;
  logic [31:0] rdata_o, exit_value_o;
  logic [7:0]  char_o;

  int checks = 0;
  int errors = 0;
  logic last_gnt;

  tb_vp_status dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_i          (req),
    .we_i           (we),
    .addr_i         (addr),
    .be_i           (be),
    .wdata_i        (wdata),
    .gnt_o          (gnt_o),
    .rvalid_o       (rvalid_o),
    .rdata_o        (rdata_o),
    .char_valid_o   (char_valid_o),
    .char_o         (char_o),
    .char_ready_i   (char_ready),
    .irq_timer_o    (irq_timer_o),
    .tests_passed_o (tests_passed_o),
    .tests_failed_o (tests_failed_o),
    .exit_valid_o   (exit_valid_o),
    .exit_value_o   (exit_value_o)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: state after each rising edge
  // --------------------------------------------------------------------------
  logic [7:0]  m_q[$];
  logic [31:0] m_timer = '0;
  logic [31:0] m_cycle = '0;
  logic        m_pass = 1'b0, m_fail = 1'b0, m_exit_v = 1'b0;
  logic [31:0] m_exit_val = '0;
  logic        exp_rvalid = 1'b0, exp_irq = 1'b0;
  logic [31:0] exp_rdata = '0;

  function automatic logic model_gnt();
    return req && !(we && addr == ADDR_PRINT && m_q.size() == DEPTH);
  endfunction

  always @(posedge clk) begin : model
    logic        g;
    logic [31:0] rd;
    if (rst) begin
      m_q.delete();
      m_timer = 0; m_cycle = 0;
      m_pass = 0; m_fail = 0; m_exit_v = 0; m_exit_val = 0;
      exp_rvalid = 0; exp_rdata = 0; exp_irq = 0;
    end else begin
      g  = model_gnt();
      rd = 0;
      if (g && !we) begin
        if (addr == ADDR_TIMER)      rd = m_timer;
        else if (addr == ADDR_CYCLE) rd = m_cycle;
      end
      exp_rvalid = g;
      exp_rdata  = rd;
      if (m_q.size() > 0 && char_ready) void'(m_q.pop_front());
      if (g && we && addr == ADDR_PRINT) m_q.push_back(wdata[7:0]);
      if (g && we && addr == ADDR_TIMER) begin
        m_timer = wdata; exp_irq = 0;
      end else if (m_timer != 0) begin
        exp_irq = (m_timer == 1); m_timer = m_timer - 1;
      end else exp_irq = 0;
      if (g && we && addr == ADDR_STATUS) begin
        if (wdata == PASS_CODE) m_pass = 1;
        if (wdata == FAIL_CODE) m_fail = 1;
      end
      if (g && we && addr == ADDR_EXIT && !m_exit_v) begin
        m_exit_v = 1; m_exit_val = wdata;
      end
      m_cycle = m_cycle + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus primitives
  // --------------------------------------------------------------------------
  task automatic drive(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic rdy);
    @(negedge clk);
    req = r; we = w; addr = a; wdata = d; be = 4'hF; char_ready = rdy;
    #1;
    last_gnt = gnt_o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // --------------------------------------------------------------------------
  // Scenarios
  // --------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    tick(); tick(); tick();
    checks++;
    if ({gnt_o, rvalid_o, rdata_o, char_valid_o, irq_timer_o} !== '0) begin
      errors++;
      $display("FAIL reset_bus: got gnt=%b rvalid=%b rdata=%h cv=%b irq=%b, expected all 0",
               gnt_o, rvalid_o, rdata_o, char_valid_o, irq_timer_o);
    end
    checks++;
    if ({tests_passed_o, tests_failed_o, exit_valid_o, exit_value_o} !== '0) begin
      errors++;
      $display("FAIL reset_status: got pass=%b fail=%b exit=%b val=%h, expected all 0",
               tests_passed_o, tests_failed_o, exit_valid_o, exit_value_o);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_cycle_read();
    for (int i = 0; i < 10; i++) tick();
    drive(1, 0, ADDR_CYCLE, 0, 0);
    checks++;
    if (last_gnt !== 1'b1) begin
      errors++; $display("FAIL cycle_gnt: got %b expected 1", last_gnt);
    end
    tick();
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'd10 || rdata_o !== exp_rdata) begin
      errors++;
      $display("FAIL cycle_read: got rvalid=%b rdata=%0d expected rvalid=1 rdata=10 (model %0d)",
               rvalid_o, rdata_o, exp_rdata);
    end
  endtask

  task automatic test_print();
    logic [7:0] exp_chars [3];
    exp_chars = '{8'h41, 8'h42, 8'h43};
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, ADDR_PRINT, {24'h0, exp_chars[i]}, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (char_valid_o !== 1'b1 || char_o !== 8'h41) begin
      errors++; $display("FAIL print_head: got valid=%b char=%h expected 1/41", char_valid_o, char_o);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 1);
      checks++;
      if (char_valid_o !== 1'b1 || char_o !== exp_chars[i]) begin
        errors++;
        $display("FAIL print_drain%0d: got valid=%b char=%h expected 1/%h",
                 i, char_valid_o, char_o, exp_chars[i]);
      end
      tick();
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (char_valid_o !== 1'b0) begin
      errors++; $display("FAIL print_empty: got valid=%b expected 0", char_valid_o);
    end
  endtask

  task automatic test_fifo_full();
    int n;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 1, ADDR_PRINT, $urandom, 0);
      checks++;
      if (last_gnt !== 1'b1) begin
        errors++; $display("FAIL fill_gnt%0d: got %b expected 1", i, last_gnt);
      end
      tick();
    end
    drive(1, 1, ADDR_PRINT, 32'h99, 0);
    checks++;
    if (last_gnt !== 1'b0) begin
      errors++; $display("FAIL full_stall: got gnt=%b expected 0", last_gnt);
    end
    tick();
    // Popping in the same cycle does not release the stall until next cycle.
    drive(1, 1, ADDR_PRINT, 32'h99, 1);
    checks++;
    if (last_gnt !== 1'b0) begin
      errors++; $display("FAIL full_pop_same_cycle: got gnt=%b expected 0", last_gnt);
    end
    tick();
    drive(1, 1, ADDR_PRINT, 32'h99, 0);
    checks++;
    if (last_gnt !== 1'b1) begin
      errors++; $display("FAIL full_release: got gnt=%b expected 1", last_gnt);
    end
    tick();
    drive(0, 0, 0, 0, 1);
    tick();
    // Seven entries: push and pop together keep occupancy at seven.
    drive(1, 1, ADDR_PRINT, 32'h5A, 1);
    checks++;
    if (last_gnt !== 1'b1) begin
      errors++; $display("FAIL push_pop_gnt: got gnt=%b expected 1", last_gnt);
    end
    tick();
    n = 0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 0, 0, 1);
      if (char_valid_o !== 1'b1) break;
      checks++;
      if (m_q.size() == 0 || char_o !== m_q[0]) begin
        errors++;
        $display("FAIL drain_order%0d: got %h expected %h", i, char_o,
                 (m_q.size() > 0) ? m_q[0] : 8'hxx);
      end
      n++;
      tick();
    end
    checks++;
    if (n != 7) begin
      errors++; $display("FAIL drain_count: got %0d entries expected 7", n);
    end
    drive(0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_timer();
    drive(1, 1, ADDR_TIMER, 32'd5, 0);
    tick();
    for (int k = 1; k <= 7; k++) begin
      if (k == 2) drive(1, 0, ADDR_TIMER, 0, 0);
      else        drive(0, 0, 0, 0, 0);
      tick();
      checks++;
      if (irq_timer_o !== (k == 5) || irq_timer_o !== exp_irq) begin
        errors++; $display("FAIL timer5_k%0d: got irq=%b expected %b", k, irq_timer_o, (k == 5));
      end
      if (k == 2) begin
        checks++;
        if (rdata_o !== 32'd4) begin
          errors++; $display("FAIL timer_read: got %0d expected 4", rdata_o);
        end
      end
    end
    drive(1, 1, ADDR_TIMER, 32'd2, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    drive(1, 1, ADDR_TIMER, 32'd3, 0);
    tick();
    checks++;
    if (irq_timer_o !== 1'b0) begin
      errors++; $display("FAIL timer_reload_wins: got irq=%b expected 0", irq_timer_o);
    end
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 0, 0, 0);
      tick();
      checks++;
      if (irq_timer_o !== (k == 3)) begin
        errors++; $display("FAIL timer3_k%0d: got irq=%b expected %b", k, irq_timer_o, (k == 3));
      end
    end
  endtask

  task automatic test_status_exit();
    drive(1, 1, ADDR_STATUS, PASS_CODE, 0);
    tick();
    checks++;
    if (tests_passed_o !== 1'b1 || tests_failed_o !== 1'b0) begin
      errors++; $display("FAIL pass_set: got pass=%b fail=%b expected 1/0", tests_passed_o, tests_failed_o);
    end
    drive(1, 1, ADDR_EXIT, 32'd7, 0);
    tick();
    drive(1, 1, ADDR_EXIT, 32'd0, 0);
    tick();
    drive(1, 1, ADDR_STATUS, 32'd5, 0);
    tick();
    drive(0, 0, 0, 0, 0);
    tick();
    checks++;
    if (exit_valid_o !== 1'b1 || exit_value_o !== 32'd7) begin
      errors++; $display("FAIL exit_frozen: got valid=%b value=%0d expected 1/7", exit_valid_o, exit_value_o);
    end
    checks++;
    if (tests_passed_o !== 1'b1 || tests_failed_o !== 1'b0) begin
      errors++; $display("FAIL pass_held: got pass=%b fail=%b expected 1/0", tests_passed_o, tests_failed_o);
    end
    drive(1, 1, ADDR_STATUS, FAIL_CODE, 0);
    tick();
    checks++;
    if (tests_passed_o !== 1'b1 || tests_failed_o !== 1'b1) begin
      errors++; $display("FAIL both_flags: got pass=%b fail=%b expected 1/1", tests_passed_o, tests_failed_o);
    end
  endtask

  task automatic test_unmapped();
    drive(1, 0, ADDR_UNMAPPED, 0, 0);
    checks++;
    if (last_gnt !== 1'b1) begin
      errors++; $display("FAIL unmapped_gnt: got %b expected 1", last_gnt);
    end
    tick();
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'd0) begin
      errors++; $display("FAIL unmapped_read: got rvalid=%b rdata=%h expected 1/0", rvalid_o, rdata_o);
    end
    drive(1, 0, ADDR_EXIT, 0, 0);
    tick();
    checks++;
    if (rvalid_o !== 1'b1 || rdata_o !== 32'd0) begin
      errors++; $display("FAIL wo_read: got rvalid=%b rdata=%h expected 1/0", rvalid_o, rdata_o);
    end
    drive(1, 1, ADDR_UNMAPPED + 32'd8, 32'hDEAD_BEEF, 0);
    tick();
    checks++;
    if (rvalid_o !== 1'b1) begin
      errors++; $display("FAIL unmapped_write_rsp: got rvalid=%b expected 1", rvalid_o);
    end
  endtask

  task automatic test_reset_pending();
    drive(1, 1, ADDR_PRINT, 32'h55, 0);
    tick();
    drive(1, 1, ADDR_PRINT, 32'h66, 0);
    tick();
    drive(1, 0, ADDR_CYCLE, 0, 0);
    rst = 1'b1;
    tick();
    checks++;
    if (rvalid_o !== 1'b0 || char_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_pending: got rvalid=%b char_valid=%b expected 0/0", rvalid_o, char_valid_o);
    end
    checks++;
    if (tests_passed_o !== 1'b0 || exit_valid_o !== 1'b0) begin
      errors++; $display("FAIL reset_clears: got pass=%b exit=%b expected 0/0", tests_passed_o, exit_valid_o);
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] addrs [6];
    logic [31:0] a, d;
    logic        w;
    addrs = '{ADDR_PRINT, ADDR_TIMER, ADDR_CYCLE, ADDR_STATUS, ADDR_EXIT, ADDR_UNMAPPED};
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 9) < 4) ? ADDR_PRINT : addrs[$urandom_range(1, 5)];
      w = $urandom_range(0, 1) == 1;
      d = $urandom;
      if (a == ADDR_TIMER) d = $urandom_range(0, 12);
      if (a == ADDR_STATUS && $urandom_range(0, 3) == 0)
        d = ($urandom_range(0, 1) == 1) ? PASS_CODE : FAIL_CODE;
      drive($urandom_range(0, 2) != 0, w, a, d, $urandom_range(0, 9) < 3);
      checks++;
      if (last_gnt !== model_gnt()) begin
        errors++; $display("FAIL rnd_gnt@%0d: got %b expected %b", i, last_gnt, model_gnt());
      end
      tick();
      checks++;
      if (rvalid_o !== exp_rvalid || rdata_o !== exp_rdata) begin
        errors++;
        $display("FAIL rnd_rsp@%0d: got rvalid=%b rdata=%h expected %b/%h",
                 i, rvalid_o, rdata_o, exp_rvalid, exp_rdata);
      end
      checks++;
      if (irq_timer_o !== exp_irq) begin
        errors++; $display("FAIL rnd_irq@%0d: got %b expected %b", i, irq_timer_o, exp_irq);
      end
      checks++;
      if (char_valid_o !== (m_q.size() > 0) || (m_q.size() > 0 && char_o !== m_q[0])) begin
        errors++;
        $display("FAIL rnd_char@%0d: got valid=%b char=%h expected valid=%b char=%h",
                 i, char_valid_o, char_o, (m_q.size() > 0), (m_q.size() > 0) ? m_q[0] : 8'h00);
      end
      checks++;
      if (tests_passed_o !== m_pass || tests_failed_o !== m_fail ||
          exit_valid_o !== m_exit_v || (m_exit_v && exit_value_o !== m_exit_val)) begin
        errors++;
        $display("FAIL rnd_status@%0d: got %b%b%b/%h expected %b%b%b/%h", i,
                 tests_passed_o, tests_failed_o, exit_valid_o, exit_value_o,
                 m_pass, m_fail, m_exit_v, m_exit_val);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_cycle_read();
    test_print();
    test_fifo_full();
    test_timer();
    test_status_exit();
    test_unmapped();
    test_reset_pending();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
